// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory port arbiter:
// arbiter state encoding, read-owner tags and the fixed read byte-enable.
package mem_arb_pkg;

    typedef enum logic {
        ST_FREE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic [3:0] MEM_FLAG_RD = 4'hf;

    // Wide enough for the largest starvation limit (15)
    localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port was denied.
// force_if tells the arbiter that fetch must win the next contest.
// The count only moves while en (arbiter free) is high; otherwise it is frozen.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] cnt_reg;
    logic [STARVE_W-1:0] cnt_next;

    // Clear when fetch is served or idle, otherwise count up to the limit
    always_comb begin
        cnt_next = cnt_reg;
        if (en) begin
            if (!if_req || if_gnt) begin
                cnt_next = '0;
            end else if (cnt_reg < MAX_C) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign force_if = (cnt_reg >= MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the instruction-fetch port and the
// data port. Data has fixed priority; a starvation limit bounds how long
// fetch can wait, and a lock keeps the memory for the data port across an
// SWP read/write pair. Read data returns one cycle after the grant.
// Optional feature macro: ARB_PERF_CNT_EN builds the conflict/stall counters;
// without it perf_conf and perf_stall are tied to zero.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic [DW-1:0] if_rdata,
    output logic          if_rvalid,
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [3:0]    d_flag,
    input  logic          d_lock,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic [DW-1:0] d_rdata,
    output logic          d_rvalid,
    output logic          mem_cen,
    output logic          mem_wen,
    output logic [3:0]    mem_flag,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   perf_conf,
    output logic [15:0]   perf_stall
);

    arb_state_t    state_reg;
    arb_state_t    state_next;
    logic          grant_d;
    logic          grant_if;
    logic          force_if;
    logic          rvalid_reg;
    owner_t        owner_reg;
    logic [DW-1:0] if_hold_reg;
    logic [DW-1:0] d_hold_reg;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .en       (state_reg == ST_FREE),
        .if_req   (if_req),
        .if_gnt   (grant_if),
        .force_if (force_if)
    );

    // Grant selection and lock tracking; nothing is granted while in reset
    always_comb begin
        grant_d    = 1'b0;
        grant_if   = 1'b0;
        state_next = state_reg;
        if (!rst) begin
            if (state_reg == ST_LOCK) begin
                grant_d = d_req;
            end else if (d_req && !force_if) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end
        end
        if (grant_d) begin
            state_next = d_lock ? ST_LOCK : ST_FREE;
        end
    end

    // Arbiter state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_FREE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign d_gnt  = grant_d;
    assign if_gnt = grant_if;

    // Memory request mux: the granted requester drives memory in the same cycle
    always_comb begin
        mem_cen   = grant_d | grant_if;
        mem_wen   = grant_d & d_wen;
        mem_flag  = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_flag  = d_wen ? d_flag : MEM_FLAG_RD;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_if) begin
            mem_flag  = MEM_FLAG_RD;
            mem_addr  = if_addr;
        end
    end

    // Remember which port owns the read data arriving next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            owner_reg  <= OWN_IF;
        end else begin
            rvalid_reg <= grant_if | (grant_d & ~d_wen);
            owner_reg  <= grant_d ? OWN_D : OWN_IF;
        end
    end

    assign if_rvalid = rvalid_reg && (owner_reg == OWN_IF);
    assign d_rvalid  = rvalid_reg && (owner_reg == OWN_D);

    // Each port keeps showing its last read word while the other port reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_hold_reg <= '0;
            d_hold_reg  <= '0;
        end else begin
            if (if_rvalid) begin
                if_hold_reg <= mem_rdata;
            end
            if (d_rvalid) begin
                d_hold_reg <= mem_rdata;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_hold_reg;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_hold_reg;

`ifdef ARB_PERF_CNT_EN
    logic [15:0] conf_reg;
    logic [15:0] stall_reg;

    // Conflict cycles (both ports asking) and fetch wins forced by starvation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conf_reg  <= '0;
            stall_reg <= '0;
        end else begin
            if (d_req && if_req) begin
                conf_reg <= conf_reg + 16'd1;
            end
            if (grant_if && force_if && d_req) begin
                stall_reg <= stall_reg + 16'd1;
            end
        end
    end

    assign perf_conf  = conf_reg;
    assign perf_stall = stall_reg;
`else
    assign perf_conf  = 16'h0;
    assign perf_stall = 16'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a rule-level model of the arbiter.
// Expected perf counters follow ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_rvalid;
    logic          d_req = 1'b0;
    logic          d_wen = 1'b0;
    logic [3:0]    d_flag = '0;
    logic          d_lock = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;
    logic          mem_cen;
    logic          mem_wen;
    logic [3:0]    mem_flag;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [15:0]   perf_conf;
    logic [15:0]   perf_stall;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .d_req(d_req), .d_wen(d_wen), .d_flag(d_flag), .d_lock(d_lock),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid),
        .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_flag(mem_flag),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .perf_conf(perf_conf), .perf_stall(perf_stall)
    );

    // SRAM environment: 256 words, byte-enabled writes, registered reads
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mem_flag[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[9:2]];
            end
        end
    end

    // Reference model state
    bit          m_locked;
    int          m_starve;
    bit          m_pv;
    bit          m_po;          // 0 fetch, 1 data
    logic [31:0] m_pd, m_lastif, m_lastd;
    int          m_conf, m_stall;
    bit          exp_dg, exp_ig, exp_force;

    // DUT samples (taken at the falling edge)
    logic        s_if_gnt, s_d_gnt, s_if_rvalid, s_d_rvalid, s_mem_wen;
    logic [3:0]  s_mem_flag;
    logic [31:0] s_if_rdata;
    logic [15:0] s_perf_conf, s_perf_stall;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_locked = 0; m_starve = 0; m_pv = 0; m_po = 0;
        m_pd = '0; m_lastif = '0; m_lastd = '0;
        m_conf = 0; m_stall = 0;
    endtask

    // Compare all outputs against the rules for the current inputs and history
    task automatic check_cycle();
        logic [3:0]  e_flag;
        logic [31:0] e_addr, e_wdata, e_ifd, e_dd;
        bit          e_ifv, e_dv;
        int          e_conf, e_stall;
        exp_dg = 0; exp_ig = 0;
        exp_force = (m_starve >= SMAX);
        if (!rst) begin
            if (m_locked) exp_dg = d_req;
            else if (d_req && !exp_force) exp_dg = 1;
            else if (if_req) exp_ig = 1;
            else if (d_req) exp_dg = 1;
        end
        e_flag  = exp_dg ? (d_wen ? d_flag : 4'hf) : (exp_ig ? 4'hf : 4'h0);
        e_addr  = exp_dg ? d_addr : (exp_ig ? if_addr : 32'h0);
        e_wdata = exp_dg ? d_wdata : 32'h0;
        e_ifv   = m_pv && !m_po;
        e_dv    = m_pv && m_po;
        e_ifd   = e_ifv ? m_pd : m_lastif;
        e_dd    = e_dv ? m_pd : m_lastd;
`ifdef ARB_PERF_CNT_EN
        e_conf  = m_conf;
        e_stall = m_stall;
`else
        e_conf  = 0;
        e_stall = 0;
`endif
        chk("d_gnt", 32'(d_gnt), 32'(exp_dg));
        chk("if_gnt", 32'(if_gnt), 32'(exp_ig));
        chk("mem_cen", 32'(mem_cen), 32'(exp_dg | exp_ig));
        chk("mem_wen", 32'(mem_wen), 32'(exp_dg & d_wen));
        chk("mem_flag", 32'(mem_flag), 32'(e_flag));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
        chk("if_rdata", if_rdata, e_ifd);
        chk("d_rdata", d_rdata, e_dd);
        chk("perf_conf", 32'(perf_conf), 32'(e_conf & 16'hffff));
        chk("perf_stall", 32'(perf_stall), 32'(e_stall & 16'hffff));
        s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rvalid = if_rvalid; s_d_rvalid = d_rvalid;
        s_mem_wen = mem_wen; s_mem_flag = mem_flag; s_if_rdata = if_rdata;
        s_perf_conf = perf_conf; s_perf_stall = perf_stall;
    endtask

    // Advance the model across the rising edge using the grants it expected
    task automatic update();
        if (rst) return;
        if (m_pv) begin
            if (m_po) m_lastd = m_pd; else m_lastif = m_pd;
        end
        m_pv = 0;
        if (exp_ig) begin m_pv = 1; m_po = 0; m_pd = sram[if_addr[9:2]]; end
        if (exp_dg && !d_wen) begin m_pv = 1; m_po = 1; m_pd = sram[d_addr[9:2]]; end
        if (d_req && if_req) m_conf = (m_conf + 1) & 16'hffff;
        if (exp_ig && exp_force && d_req) m_stall = (m_stall + 1) & 16'hffff;
        if (!m_locked) begin
            if (!if_req || exp_ig) m_starve = 0;
            else if (m_starve < SMAX) m_starve++;
        end
        if (exp_dg) m_locked = d_lock;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        update();
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 0; d_req = 0; d_wen = 0; d_lock = 0; d_flag = 0;
    endtask

    task automatic do_reset();
        rst = 1; model_reset(); idle_inputs();
        step();
        rst = 0;
    endtask

    string gseq;
    bit    if_pend, d_pend, swp_wr;

    initial begin
        for (int i = 0; i < 256; i++) sram[i] = $urandom;
        model_reset();

        // Reset state: everything quiet
        step();
        chk("reset_if_gnt", 32'(s_if_gnt), 32'h0);
        chk("reset_perf_conf", 32'(s_perf_conf), 32'h0);
        rst = 0;

        // 1) Lone fetch: granted at once, data next cycle
        sram[8'h40] = 32'hE3A00001;
        if_req = 1; if_addr = 32'h100;
        step();
        chk("t1_if_gnt", 32'(s_if_gnt), 32'h1);
        if_req = 0;
        step();
        chk("t1_if_rvalid", 32'(s_if_rvalid), 32'h1);
        chk("t1_if_rdata", s_if_rdata, 32'hE3A00001);

        // 2) Partial-byte write
        d_req = 1; d_wen = 1; d_flag = 4'b0011; d_addr = 32'h40000010; d_wdata = 32'h1234;
        step();
        chk("t2_mem_wen", 32'(s_mem_wen), 32'h1);
        chk("t2_mem_flag", 32'(s_mem_flag), 32'h3);
        idle_inputs();
        step();
        chk("t2_d_rvalid", 32'(s_d_rvalid), 32'h0);

        // 3) Continuous contention from a clean start
        do_reset();
        d_req = 1; d_wen = 0; d_addr = 32'h20; if_req = 1; if_addr = 32'h104;
        gseq = "";
        for (int c = 0; c < 6; c++) begin
            step();
            gseq = {gseq, s_d_gnt ? "D" : (s_if_gnt ? "F" : "-")};
        end
        chk("t3_grant_order", (gseq == "DDDDFD") ? 32'h1 : 32'h0, 32'h1);
        idle_inputs();
        step();
`ifdef ARB_PERF_CNT_EN
        chk("t3_perf_stall", 32'(s_perf_stall), 32'h1);
        chk("t3_perf_conf", 32'(s_perf_conf), 32'h6);
`else
        chk("t3_perf_stall", 32'(s_perf_stall), 32'h0);
        chk("t3_perf_conf", 32'(s_perf_conf), 32'h0);
`endif

        // 4) SWP with a fetch waiting throughout the lock
        d_req = 1; d_wen = 0; d_lock = 1; d_addr = 32'h24; if_req = 1; if_addr = 32'h108;
        step();
        chk("t4_lock_rd_gnt", 32'(s_d_gnt), 32'h1);
        d_req = 0; d_lock = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("t4_if_blocked", 32'(s_if_gnt), 32'h0);
        end
        d_req = 1; d_wen = 1; d_flag = 4'hf; d_wdata = 32'hCAFE0001;
        step();
        chk("t4_wr_gnt", 32'(s_d_gnt), 32'h1);
        chk("t4_wr_if_blocked", 32'(s_if_gnt), 32'h0);
        d_req = 0; d_wen = 0;
        step();
        chk("t4_if_after_unlock", 32'(s_if_gnt), 32'h1);
        idle_inputs();
        step();

        // 5) Reset right after a read grant drops the pending read
        d_req = 1; d_wen = 0; d_addr = 32'h8;
        step();
        rst = 1; model_reset(); d_req = 0; if_req = 1;
        step();
        chk("t5_d_rvalid", 32'(s_d_rvalid), 32'h0);
        chk("t5_if_gnt", 32'(s_if_gnt), 32'h0);
        rst = 0; idle_inputs();
        step();

        // Random traffic; requests held until the model says they were granted
        if_pend = 0; d_pend = 0; swp_wr = 0;
        for (int c = 0; c < 3000; c++) begin
            if (exp_ig) if_pend = 0;
            if (exp_dg) d_pend = 0;
            if (!if_pend && $urandom_range(99) < 60) begin
                if_pend = 1;
                if_addr = 32'($urandom_range(255)) << 2;
            end
            if_req = if_pend;
            if (!d_pend && $urandom_range(99) < 50) begin
                d_pend = 1;
                d_wdata = $urandom;
                if (swp_wr) begin
                    d_wen = 1; d_lock = 0; d_flag = 4'hf; swp_wr = 0;
                end else begin
                    d_lock = ($urandom_range(99) < 10);
                    d_wen  = d_lock ? 1'b0 : 1'($urandom_range(1));
                    d_flag = 4'($urandom_range(15));
                    d_addr = 32'($urandom_range(255)) << 2;
                    swp_wr = d_lock;
                end
            end
            d_req = d_pend;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
